// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecR,
    StExecI,
    StAluWb,
    StBranch
  } mc_state_e;

  // ALU operations; the 2-bit encodings are the low bits of the 3-bit ones.
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOrr = 3'b011;
  localparam logic [2:0] AluEor = 3'b100;

  // Data-processing cmd field, Funct[4:1].
  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdEor = 4'b0001;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondNe = 4'h1;
  localparam logic [3:0] CondCs = 4'h2;
  localparam logic [3:0] CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4;
  localparam logic [3:0] CondPl = 4'h5;
  localparam logic [3:0] CondVs = 4'h6;
  localparam logic [3:0] CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8;
  localparam logic [3:0] CondLs = 4'h9;
  localparam logic [3:0] CondGe = 4'hA;
  localparam logic [3:0] CondLt = 4'hB;
  localparam logic [3:0] CondGt = 4'hC;
  localparam logic [3:0] CondLe = 4'hD;
  localparam logic [3:0] CondAl = 4'hE;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBExt  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and condition evaluation; cond_ex is latched once per instruction.
module cond_unit #(
  parameter bit FULL_COND = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic       flag_we_nz_i,
  input  logic       flag_we_cv_i,
  input  logic       cond_ex_we_i,
  output logic       cond_ex_o
);
  import mc_pkg::*;

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_met;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_met = 1'b0;
    if (FULL_COND) begin
      case (cond_i)
        CondEq:  cond_met = z;
        CondNe:  cond_met = ~z;
        CondCs:  cond_met = c;
        CondCc:  cond_met = ~c;
        CondMi:  cond_met = n;
        CondPl:  cond_met = ~n;
        CondVs:  cond_met = v;
        CondVc:  cond_met = ~v;
        CondHi:  cond_met = c & ~z;
        CondLs:  cond_met = ~c | z;
        CondGe:  cond_met = (n == v);
        CondLt:  cond_met = (n != v);
        CondGt:  cond_met = ~z & (n == v);
        CondLe:  cond_met = z | (n != v);
        CondAl:  cond_met = 1'b1;
        default: cond_met = 1'b0;
      endcase
    end else begin
      case (cond_i)
        CondEq:  cond_met = z;
        CondNe:  cond_met = ~z;
        CondAl:  cond_met = 1'b1;
        default: cond_met = 1'b0;
      endcase
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_we_nz_i) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_we_cv_i) flags_d[1:0] = alu_flags_i[1:0];
    cond_ex_d = cond_ex_we_i ? cond_met : cond_ex_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex_o = cond_ex_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, data-processing decode and write gating.
module multicycle_ctrl #(
  parameter int unsigned ALUCTRL_W = 2,
  parameter bit          FULL_COND = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal
);
  import mc_pkg::*;

  mc_state_e            state_q, state_d;
  logic [ALUCTRL_W-1:0] dp_alu;
  logic                 dp_nowrite, dp_arith, dp_cmp;
  logic                 cond_ex;
  logic                 flag_we_nz, flag_we_cv, cond_ex_we;
  logic                 rd_pc, dp_wb;

  assign rd_pc = (Rd == 4'hF);
  assign dp_wb = cond_ex & ~dp_nowrite;

  cond_unit #(
    .FULL_COND(FULL_COND)
  ) u_cond (
    .clk          (clk),
    .reset        (reset),
    .cond_i       (Cond),
    .alu_flags_i  (ALUFlags),
    .flag_we_nz_i (flag_we_nz),
    .flag_we_cv_i (flag_we_cv),
    .cond_ex_we_i (cond_ex_we),
    .cond_ex_o    (cond_ex)
  );

  // Unknown cmd codes execute as ADD but never write back.
  always_comb begin
    dp_alu     = ALUCTRL_W'(AluAdd);
    dp_nowrite = 1'b0;
    dp_arith   = 1'b1;
    dp_cmp     = 1'b0;
    case (Funct[4:1])
      CmdAdd: dp_alu = ALUCTRL_W'(AluAdd);
      CmdSub: dp_alu = ALUCTRL_W'(AluSub);
      CmdAnd: begin
        dp_alu   = ALUCTRL_W'(AluAnd);
        dp_arith = 1'b0;
      end
      CmdOrr: begin
        dp_alu   = ALUCTRL_W'(AluOrr);
        dp_arith = 1'b0;
      end
      CmdCmp: begin
        dp_alu     = ALUCTRL_W'(AluSub);
        dp_nowrite = 1'b1;
        dp_cmp     = 1'b1;
      end
      CmdEor: begin
        if (ALUCTRL_W >= 3) begin
          dp_alu   = ALUCTRL_W'(AluEor);
          dp_arith = 1'b0;
        end
      end
      default: dp_nowrite = 1'b1;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      2'b01: begin
        ImmSrc = 2'b01;
        RegSrc = {~Funct[0], 1'b0};
      end
      2'b10: begin
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = ResAluOut;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SrcBRd2;
    ALUControl = ALUCTRL_W'(AluAdd);
    Illegal    = 1'b0;
    flag_we_nz = 1'b0;
    flag_we_cv = 1'b0;
    cond_ex_we = 1'b0;
    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        PCWrite   = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SrcBFour;
        cond_ex_we = 1'b1;
        unique case (Op)
          2'b00: state_d = Funct[5] ? StExecI : StExecR;
          2'b01: state_d = StMemAdr;
          2'b10: state_d = StBranch;
          2'b11: begin
            Illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcB = SrcBExt;
        state_d = Funct[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        AdrSrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & rd_pc;
        state_d   = StFetch;
      end
      StMemWr: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
        state_d  = StFetch;
      end
      StExecR, StExecI: begin
        ALUSrcB    = (state_q == StExecI) ? SrcBExt : SrcBRd2;
        ALUControl = dp_alu;
        flag_we_nz = cond_ex & (Funct[0] | dp_cmp);
        flag_we_cv = cond_ex & (Funct[0] | dp_cmp) & dp_arith;
        state_d    = StAluWb;
      end
      StAluWb: begin
        RegWrite = dp_wb;
        PCWrite  = dp_wb & rd_pc;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcB   = SrcBExt;
        ResultSrc = ResAluResult;
        PCWrite   = cond_ex;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // Reset must never leak an architectural write, whatever the current state.
    if (reset) begin
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      Illegal    = 1'b0;
      flag_we_nz = 1'b0;
      flag_we_cv = 1'b0;
      cond_ex_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic       clk, reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, Illegal;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       pcw, memw, regw, irw, adr;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] alu;
    logic       ill;
    logic [1:0] imm;
    logic [1:0] rsrc;
  } ctl_t;

  ctl_t       exp_q[$];
  ctl_t       obs_q[$];
  logic [3:0] mflags;  // model NZCV

  multicycle_ctrl #(
    .ALUCTRL_W (2),
    .FULL_COND (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .Illegal    (Illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctl_t base(input logic [1:0] op, input logic [5:0] funct);
    ctl_t c;
    c = '0;
    if (op == 2'b01) begin
      c.imm  = 2'b01;
      c.rsrc = {!funct[0], 1'b0};
    end else if (op == 2'b10) begin
      c.imm  = 2'b10;
      c.rsrc = 2'b01;
    end
    return c;
  endfunction

  // Per-cycle expectations for one instruction; also advances the flag model.
  function automatic void build(input logic [3:0] cond, input logic [1:0] op,
                                input logic [5:0] funct, input logic [3:0] rd,
                                input logic [3:0] af);
    ctl_t       c;
    logic       pass, wr, cv, cmp;
    logic [1:0] alu;
    pass = cond_ok(cond, mflags);
    c = base(op, funct);
    c.pcw = 1; c.irw = 1; c.res = 2'b10; c.srca = 1; c.srcb = 2'b10;
    exp_q.push_back(c);
    c = base(op, funct);
    c.srca = 1; c.srcb = 2'b10; c.ill = (op == 2'b11);
    exp_q.push_back(c);
    case (op)
      2'b01: begin
        c = base(op, funct); c.srcb = 2'b01;
        exp_q.push_back(c);
        if (funct[0]) begin
          c = base(op, funct); c.adr = 1;
          exp_q.push_back(c);
          c = base(op, funct); c.res = 2'b01; c.regw = pass; c.pcw = pass && rd == 4'hF;
          exp_q.push_back(c);
        end else begin
          c = base(op, funct); c.adr = 1; c.memw = pass;
          exp_q.push_back(c);
        end
      end
      2'b00: begin
        wr = 1; cv = 1; cmp = 0; alu = 2'b00;
        case (funct[4:1])
          4'b0100: alu = 2'b00;
          4'b0010: alu = 2'b01;
          4'b0000: begin alu = 2'b10; cv = 0; end
          4'b1100: begin alu = 2'b11; cv = 0; end
          4'b1010: begin alu = 2'b01; wr = 0; cmp = 1; end
          4'b0001: alu = 2'b00;  // EOR is plain ADD with a 2-bit ALU
          default: wr = 0;
        endcase
        c = base(op, funct); c.srcb = funct[5] ? 2'b01 : 2'b00; c.alu = alu;
        exp_q.push_back(c);
        c = base(op, funct); c.regw = pass && wr; c.pcw = pass && wr && rd == 4'hF;
        exp_q.push_back(c);
        if (pass && (funct[0] || cmp)) begin
          mflags[3:2] = af[3:2];
          if (cv) mflags[1:0] = af[1:0];
        end
      end
      2'b10: begin
        c = base(op, funct); c.srcb = 2'b01; c.res = 2'b10; c.pcw = pass;
        exp_q.push_back(c);
      end
      default: ;
    endcase
  endfunction

  function automatic ctl_t observe();
    return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
            ALUControl, Illegal, ImmSrc, RegSrc};
  endfunction

  task automatic run_word(input logic [31:0] w, input logic [3:0] af);
    Cond = w[31:28]; Op = w[27:26]; Funct = w[25:20]; Rd = w[15:12]; ALUFlags = af;
    exp_q.delete();
    obs_q.delete();
    build(w[31:28], w[27:26], w[25:20], w[15:12], af);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      obs_q.push_back(observe());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1; Op = 2'b11; Cond = 4'hE; Funct = 6'h3F; Rd = 4'hF; ALUFlags = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({PCWrite, MemWrite, RegWrite, IRWrite, Illegal} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: enables got %b required 00000", i,
                 {PCWrite, MemWrite, RegWrite, IRWrite, Illegal});
      end
      @(posedge clk);
      #1;
    end
    reset = 0;
    mflags = 4'b0000;
    // Flags are zero after reset: probe every condition code with a branch.
    for (int c = 0; c < 16; c++) begin
      logic [31:0] w;
      w = 32'h0A000002;
      w[31:28] = 4'(c);
      run_word(w, 4'hF);
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL reset_flags cond%0d cyc%0d: got %h required %h", c, k, obs_q[k],
                   exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [35:0] dir [12] = '{
      {32'hE0821003, 4'h0}, {32'hE3510005, 4'h4}, {32'h0A000002, 4'h0},
      {32'h1A000002, 4'h0}, {32'hE5912004, 4'h0}, {32'hE3510005, 4'h0},
      {32'h05812004, 4'h0}, {32'hE591F004, 4'h0}, {32'hE082F003, 4'h0},
      {32'hE0221003, 4'h0}, {32'hE1E01003, 4'h0}, {32'hE0921003, 4'hB}};
    for (int i = 0; i < 12; i++) begin
      run_word(dir[i][35:4], dir[i][3:0]);
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL directed %h cyc%0d: got %h required %h", dir[i][35:4], k, obs_q[k],
                   exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ws [2] = '{32'hEC000000, 32'h4E000000};
    for (int i = 0; i < 2; i++) begin
      run_word(ws[i], 4'h0);
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL illegal %h cyc%0d: got %h required %h", ws[i], k, obs_q[k],
                   exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'h2; ALUFlags = 4'h0;
    exp_q.delete();
    build(4'hE, 2'b01, 6'b011000, 4'h2, 4'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (observe() !== exp_q[k]) begin
        n_fail++;
        $display("FAIL reset_mid pre cyc%0d: got %h required %h", k, observe(), exp_q[k]);
      end
      @(posedge clk);
      #1;
    end
    reset = 1;  // now in MEMWR
    @(negedge clk);
    n_cmp++;
    if ({MemWrite, AdrSrc} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid memwr: {MemWrite,AdrSrc} got %b required 01", {MemWrite, AdrSrc});
    end
    @(posedge clk);
    #1;
    reset = 0;
    mflags = 4'b0000;
    run_word(32'hE0821003, 4'h0);
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL reset_mid post cyc%0d: got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  cmds [6] = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA, 4'h1};
    logic [31:0] w;
    int          r;
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      r = $urandom_range(0, 9);
      w[27:26] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
      if (w[27:26] == 2'b00 && $urandom_range(0, 1) == 1) w[24:21] = cmds[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
      run_word(w, 4'($urandom));
      for (int k = 0; k < exp_q.size(); k++) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random[%0d] %h cyc%0d: got %h required %h", i, w, k, obs_q[k],
                   exp_q[k]);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (IRWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL random_end fetch: IRWrite got %b required 1", IRWrite);
    end
  endtask

  initial begin
    reset = 1; Cond = 4'h0; Op = 2'b00; Funct = 6'h0; Rd = 4'h0; ALUFlags = 4'h0;
    mflags = 4'b0000;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
